adc_display_meas: RTL and testbench

//  Upstream feeder of the 4-digit seven-seg display driver. Consumes the scope ADC sample stream,

---
 rtl/scope_disp_pkg.sv | 29 ++
 rtl/scale_sat.sv | 53 +++++
 rtl/adc_display_meas.sv | 141 ++++++++++++++
 tb/tb_adc_display_meas.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/scope_disp_pkg.sv
// +----------------------------------------------------------------------------+
// | scope_disp_pkg : shared types and widths for the display measurement path   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package scope_disp_pkg;

    localparam int NUM_W    = 13;
    localparam int DISP_MAX = 4095;
    localparam int ADC_W    = 12;
    localparam int PROD_W   = 25;

    typedef enum logic [1:0] {
        MODE_INST = 2'd0,
        MODE_MAX  = 2'd1,
        MODE_MIN  = 2'd2,
        MODE_PP   = 2'd3
    } meas_mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MULT = 2'd1,
        S_SAT  = 2'd2
    } res_state_e;

endpackage

`default_nettype wire

// File: rtl/scale_sat.sv
// +----------------------------------------------------------------------------+
// | scale_sat : registered raw*SCALE_NUM product, then arithmetic shift and     |
// | symmetric clamp to +/-DISP_MAX.                                             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module scale_sat
    import scope_disp_pkg::*;
#(
    parameter int SCALE_NUM   = 825,
    parameter int SCALE_SHIFT = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic signed [NUM_W-1:0] raw,
    output logic signed [NUM_W-1:0] sat
);

    localparam logic signed [PROD_W-1:0] c_scale = PROD_W'(SCALE_NUM);
    localparam logic signed [PROD_W-1:0] c_pos   = PROD_W'(DISP_MAX);
    localparam logic signed [PROD_W-1:0] c_neg   = -c_pos;

    logic signed [PROD_W-1:0] r_prod;
    logic signed [PROD_W-1:0] w_raw_ext;
    logic signed [PROD_W-1:0] w_shift;

    assign w_raw_ext = {{(PROD_W-NUM_W){raw[NUM_W-1]}}, raw};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prod <= '0;
        end else if (load) begin
            r_prod <= w_raw_ext * c_scale;
        end
    end

    // Arithmetic shift floors toward -inf, so negative results round away from zero.
    assign w_shift = r_prod >>> SCALE_SHIFT;

    always_comb begin
        sat = w_shift[NUM_W-1:0];
        if (w_shift > c_pos) begin
            sat = c_pos[NUM_W-1:0];
        end else if (w_shift < c_neg) begin
            sat = c_neg[NUM_W-1:0];
        end
    end

endmodule

`default_nettype wire

// File: rtl/adc_display_meas.sv
// +----------------------------------------------------------------------------+
// | adc_display_meas : windowed ADC measurement (inst/max/min/p-p) scaled to mV |
// | for the seven-seg driver. Optional DISP_AVG_EN: mode 0 reports the average. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module adc_display_meas
    import scope_disp_pkg::*;
#(
    parameter int WINDOW_SAMPLES = 1024,
    parameter int SCALE_NUM      = 825,
    parameter int SCALE_SHIFT    = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sample_valid,
    input  logic signed [ADC_W-1:0] sample,
    input  logic [1:0]              mode,
    input  logic                    hold,
    output logic signed [NUM_W-1:0] num,
    output logic                    num_update,
    output logic                    win_done
);

    localparam int              CNT_W  = $clog2(WINDOW_SAMPLES);
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WINDOW_SAMPLES - 1);

    logic [CNT_W-1:0]        r_count;
    logic                    r_first;
    logic signed [ADC_W-1:0] r_max;
    logic signed [ADC_W-1:0] r_min;
    logic signed [NUM_W-1:0] r_raw;
    res_state_e              r_state;

    logic                    w_close;
    logic signed [ADC_W-1:0] w_max_next;
    logic signed [ADC_W-1:0] w_min_next;
    logic signed [ADC_W-1:0] w_inst;
    logic signed [NUM_W-1:0] w_raw;
    logic signed [NUM_W-1:0] w_sat;

    assign w_close    = sample_valid && (r_count == c_last);
    assign w_max_next = (r_first || (sample > r_max)) ? sample : r_max;
    assign w_min_next = (r_first || (sample < r_min)) ? sample : r_min;

`ifdef DISP_AVG_EN
    localparam int ACC_W = ADC_W + CNT_W;

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_acc_next;

    assign w_acc_next = r_acc + {{CNT_W{sample[ADC_W-1]}}, sample};
    // Window length is a power of two, so the mean is an exact arithmetic shift.
    assign w_inst     = ADC_W'(w_acc_next >>> CNT_W);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (sample_valid) begin
            r_acc <= w_close ? '0 : w_acc_next;
        end
    end
`else
    assign w_inst = sample;
`endif

    always_comb begin
        w_raw = {w_inst[ADC_W-1], w_inst};
        case (meas_mode_e'(mode))
            MODE_MAX: w_raw = {w_max_next[ADC_W-1], w_max_next};
            MODE_MIN: w_raw = {w_min_next[ADC_W-1], w_min_next};
            MODE_PP:  w_raw = {w_max_next[ADC_W-1], w_max_next}
                            - {w_min_next[ADC_W-1], w_min_next};
            default:  w_raw = {w_inst[ADC_W-1], w_inst};
        endcase
    end

    scale_sat #(
        .SCALE_NUM   (SCALE_NUM),
        .SCALE_SHIFT (SCALE_SHIFT)
    ) u_scale_sat (
        .clk   (clk),
        .reset (reset),
        .load  (r_state == S_MULT),
        .raw   (r_raw),
        .sat   (w_sat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count    <= '0;
            r_first    <= 1'b1;
            r_max      <= '0;
            r_min      <= '0;
            r_raw      <= '0;
            r_state    <= S_IDLE;
            num        <= '0;
            num_update <= 1'b0;
            win_done   <= 1'b0;
        end else begin
            num_update <= 1'b0;
            win_done   <= w_close;

            if (sample_valid) begin
                if (w_close) begin
                    r_count <= '0;
                    r_first <= 1'b1;
                    r_raw   <= w_raw;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                    r_first <= 1'b0;
                    r_max   <= w_max_next;
                    r_min   <= w_min_next;
                end
            end

            // A close always (re)starts the pipeline; the product register is
            // separate, so an in-flight S_SAT still completes the same cycle.
            case (r_state)
                S_IDLE: begin
                    if (w_close) r_state <= S_MULT;
                end
                S_MULT: begin
                    r_state <= w_close ? S_MULT : S_SAT;
                end
                S_SAT: begin
                    if (!hold) begin
                        num        <= w_sat;
                        num_update <= 1'b1;
                    end
                    r_state <= w_close ? S_MULT : S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_adc_display_meas.sv
// +----------------------------------------------------------------------------+
// | tb_adc_display_meas : directed vectors on two 4-sample-window instances     |
// | (825/1024 scaling and 4095/1 saturation). Honours DISP_AVG_EN.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_adc_display_meas;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               sample_valid = 1'b0;
    logic signed [11:0] sample = '0;
    logic [1:0]         mode = 2'd0;
    logic               hold = 1'b0;
    logic signed [12:0] num;
    logic               num_update;
    logic               win_done;
    logic signed [12:0] num_s;
    logic               num_update_s;
    logic               win_done_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    adc_display_meas #(
        .WINDOW_SAMPLES (4),
        .SCALE_NUM      (825),
        .SCALE_SHIFT    (10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .mode         (mode),
        .hold         (hold),
        .num          (num),
        .num_update   (num_update),
        .win_done     (win_done)
    );

    adc_display_meas #(
        .WINDOW_SAMPLES (4),
        .SCALE_NUM      (4095),
        .SCALE_SHIFT    (0)
    ) dut_sat (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .mode         (mode),
        .hold         (hold),
        .num          (num_s),
        .num_update   (num_update_s),
        .win_done     (win_done_s)
    );

    typedef struct {
        logic [1:0] mode;
        bit         hold;
        int         s0, s1, s2, s3;
        int         exp;
        int         exp_sat;
        bit         upd;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Mode is scrambled until the closing sample to show only its final value matters.
    task automatic run_window(input vec_t v);
        int s[4];
        s[0] = v.s0; s[1] = v.s1; s[2] = v.s2; s[3] = v.s3;
        hold = v.hold;
        for (int i = 0; i < 4; i++) begin
            sample       = 12'(s[i]);
            mode         = (i == 3) ? v.mode : ~v.mode;
            sample_valid = 1'b1;
            tick();
            check("win_done", int'(win_done), (i == 3) ? 1 : 0);
        end
        sample_valid = 1'b0;
        tick();
        check("num_update_early", int'(num_update), 0);
        tick();
        check("num", int'(num), v.exp);
        check("num_update", int'(num_update), int'(v.upd));
        check("num_sat", int'(num_s), v.exp_sat);
        check("num_update_sat", int'(num_update_s), int'(v.upd));
        hold = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{mode: 2'd1, hold: 0, s0: 10,    s1: -5,   s2: 300,   s3: 7,     exp: 241,   exp_sat: 4095,  upd: 1};
        vecs[1]  = '{mode: 2'd3, hold: 0, s0: -2048, s1: 2047, s2: 0,     s3: 0,     exp: 3299,  exp_sat: 4095,  upd: 1};
        vecs[2]  = '{mode: 2'd2, hold: 0, s0: -2048, s1: 2047, s2: 0,     s3: 0,     exp: -1650, exp_sat: -4095, upd: 1};
        vecs[3]  = '{mode: 2'd0, hold: 0, s0: -2048, s1: -2048, s2: -2048, s3: -2048, exp: -1650, exp_sat: -4095, upd: 1};
        vecs[4]  = '{mode: 2'd0, hold: 0, s0: 1,     s1: 1,    s2: 1,     s3: 1,     exp: 0,     exp_sat: 4095,  upd: 1};
        vecs[5]  = '{mode: 2'd1, hold: 0, s0: -100,  s1: -50,  s2: -7,    s3: -300,  exp: -6,    exp_sat: -4095, upd: 1};
        vecs[6]  = '{mode: 2'd1, hold: 1, s0: 100,   s1: 0,    s2: 0,     s3: 0,     exp: -6,    exp_sat: -4095, upd: 0};
        vecs[7]  = '{mode: 2'd2, hold: 0, s0: 100,   s1: 200,  s2: 300,   s3: 400,   exp: 80,    exp_sat: 4095,  upd: 1};
        vecs[8]  = '{mode: 2'd1, hold: 0, s0: -10,   s1: -20,  s2: -30,   s3: -40,   exp: -9,    exp_sat: -4095, upd: 1};
        vecs[9]  = '{mode: 2'd3, hold: 0, s0: 5,     s1: 5,    s2: 5,     s3: 5,     exp: 0,     exp_sat: 0,     upd: 1};
`ifdef DISP_AVG_EN
        vecs[10] = '{mode: 2'd0, hold: 0, s0: 4,     s1: 8,    s2: 12,    s3: 16,    exp: 8,     exp_sat: 4095,  upd: 1};
`else
        vecs[10] = '{mode: 2'd0, hold: 0, s0: 4,     s1: 8,    s2: 12,    s3: 16,    exp: 12,    exp_sat: 4095,  upd: 1};
`endif

        // Reset held with live samples: nothing may escape.
        reset        = 1'b1;
        sample_valid = 1'b1;
        mode         = 2'd1;
        for (int i = 0; i < 3; i++) begin
            sample = (i % 2 == 0) ? 12'sd1000 : -12'sd1000;
            tick();
            check("reset_num", int'(num), 0);
            check("reset_num_update", int'(num_update), 0);
            check("reset_win_done", int'(win_done), 0);
        end
        reset        = 1'b0;
        sample_valid = 1'b0;
        tick();
        check("idle_win_done", int'(win_done), 0);

        for (int k = 0; k < 11; k++) begin
            run_window(vecs[k]);
        end

        // Back-to-back windows: window B must be seeded by its own first sample.
        begin
            int s[8];
            s[0] = 1000; s[1] = 2000; s[2] = 1500; s[3] = -3;
            s[4] = -10;  s[5] = -20;  s[6] = -30;  s[7] = -40;
            mode = 2'd1;
            for (int i = 0; i < 8; i++) begin
                sample       = 12'(s[i]);
                sample_valid = 1'b1;
                tick();
                check("b2b_win_done", int'(win_done), (i == 3 || i == 7) ? 1 : 0);
                if (i == 5) begin
                    check("b2b_num_a", int'(num), 1611);
                    check("b2b_upd_a", int'(num_update), 1);
                end
            end
            sample_valid = 1'b0;
            tick();
            tick();
            check("b2b_num_b", int'(num), -9);
            check("b2b_upd_b", int'(num_update), 1);
            check("b2b_num_b_sat", int'(num_s), -4095);
        end

        // Reset mid-window discards the partial window and clears num.
        mode         = 2'd1;
        sample       = 12'sd2000;
        sample_valid = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("midreset_num", int'(num), 0);
        check("midreset_win_done", int'(win_done), 0);
        reset        = 1'b0;
        sample_valid = 1'b0;
        run_window('{mode: 2'd2, hold: 0, s0: 100, s1: 100, s2: 100, s3: 100,
                     exp: 80, exp_sat: 4095, upd: 1});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
